// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle sequencing controller for the MIPS CPU: steps each instruction through
// fetch/decode/execute/memory/writeback, stalls on bus wait-request and MULT/DIV latency,
// tracks the branch delay slot and halts when the PC reaches zero.
module mips_cpu_control_fsm #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [31:0] instr_i,
    input  logic        mem_waitrequest_i,
    input  logic        alu_cond_i,
    input  logic        pc_zero_i,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        addr_sel_o,
    output logic        ir_write_o,
    output logic        target_write_o,
    output logic        pc_write_o,
    output logic        pc_src_o,
    output logic        reg_write_o,
    output logic        hilo_write_o,
    output logic [2:0]  state_o,
    output logic        active_o
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMulDiv = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalted = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            delay_pending_q, delay_pending_d;

    logic [5:0] op, funct;
    logic [4:0] rt;
    logic       is_load, is_store, is_muldiv, is_div, is_branch, is_jump, is_link, is_alu;
    logic       muldiv_one;
    logic       complete;
    logic       unused_instr;

    assign op           = instr_i[31:26];
    assign rt           = instr_i[20:16];
    assign funct        = instr_i[5:0];
    assign unused_instr = ^{instr_i[25:21], instr_i[15:6]};

    // Instruction class decode from the instruction register.
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_muldiv = 1'b0;
        is_div    = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        is_link   = 1'b0;
        is_alu    = 1'b0;
        case (op)
            6'd0: begin
                case (funct)
                    6'd8:  is_jump = 1'b1;
                    6'd9:  begin is_jump = 1'b1; is_link = 1'b1; end
                    6'd24, 6'd25: is_muldiv = 1'b1;
                    6'd26, 6'd27: begin is_muldiv = 1'b1; is_div = 1'b1; end
                    6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7,
                    6'd16, 6'd17, 6'd18, 6'd19,
                    6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                    6'd42, 6'd43: is_alu = 1'b1;
                    default: ;
                endcase
            end
            6'd1: begin
                case (rt)
                    5'd0, 5'd1:   is_branch = 1'b1;
                    5'd16, 5'd17: begin is_branch = 1'b1; is_link = 1'b1; end
                    default: ;
                endcase
            end
            6'd2: is_jump = 1'b1;
            6'd3: begin is_jump = 1'b1; is_link = 1'b1; end
            6'd4, 6'd5, 6'd6, 6'd7: is_branch = 1'b1;
            6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15: is_alu = 1'b1;
            6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38: is_load = 1'b1;
            6'd40, 6'd41, 6'd43: is_store = 1'b1;
            default: ;
        endcase
    end

    assign muldiv_one = is_div ? (DIV_CYCLES == 32'd1) : (MULT_CYCLES == 32'd1);

    // Next-state and strobe decode; completion is folded in at the end.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        delay_pending_d = delay_pending_q;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        addr_sel_o      = 1'b0;
        ir_write_o      = 1'b0;
        target_write_o  = 1'b0;
        pc_write_o      = 1'b0;
        pc_src_o        = 1'b0;
        reg_write_o     = 1'b0;
        hilo_write_o    = 1'b0;
        complete        = 1'b0;
        unique case (state_q)
            StFetch: begin
                // A pending delay-slot target means PC==0 is transient, so keep fetching.
                if (pc_zero_i && !delay_pending_q) begin
                    state_d = StHalted;
                end else begin
                    mem_read_o = 1'b1;
                    if (!mem_waitrequest_i) begin
                        ir_write_o = 1'b1;
                        state_d    = StDecode;
                    end
                end
            end
            StDecode: state_d = StExec;
            StExec: begin
                if (is_alu) begin
                    reg_write_o = 1'b1;
                    complete    = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_muldiv) begin
                    if (muldiv_one) begin
                        hilo_write_o = 1'b1;
                        complete     = 1'b1;
                    end else begin
                        cnt_d   = is_div ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
                        state_d = StMulDiv;
                    end
                end else if (is_branch) begin
                    // Control transfer inside a delay slot is ignored.
                    target_write_o = alu_cond_i && !delay_pending_q;
                    reg_write_o    = is_link;
                    complete       = 1'b1;
                end else if (is_jump) begin
                    target_write_o = !delay_pending_q;
                    reg_write_o    = is_link;
                    complete       = 1'b1;
                end else begin
                    complete = 1'b1;
                end
            end
            StMulDiv: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hilo_write_o = 1'b1;
                    complete     = 1'b1;
                end
            end
            StMem: begin
                addr_sel_o  = 1'b1;
                mem_read_o  = is_load;
                mem_write_o = is_store;
                if (!mem_waitrequest_i) begin
                    if (is_load) state_d = StWb;
                    else         complete = 1'b1;
                end
            end
            StWb: begin
                reg_write_o = 1'b1;
                complete    = 1'b1;
            end
            StHalted: ;
            default: state_d = StFetch;
        endcase
        if (complete) begin
            pc_write_o      = 1'b1;
            pc_src_o        = delay_pending_q;
            delay_pending_d = target_write_o;
            state_d         = StFetch;
        end
    end

    // State, MULT/DIV counter and delay-slot flag registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= StFetch;
            cnt_q           <= '0;
            delay_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            delay_pending_q <= delay_pending_d;
        end
    end

    assign state_o  = state_q;
    assign active_o = (state_q != StHalted);

endmodule

// File: doc/mips_cpu_control_fsm.md
# mips_cpu_control_fsm

Multi-cycle sequencing controller for the MIPS CPU, the successor to the single-cycle combinational decoder. Sequences every instruction through fetch, decode, execute, memory and writeback phases, and stalls on a shared-memory wait-request and on parametrised-latency MULT/DIV. Implements the branch delay slot and halt-on-PC-zero. Sits between the memory bus interface and the datapath; the datapath muxes are driven from this block's outputs.

## Interface
- MULT_CYCLES, 4: execute-phase cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 32: execute-phase cycles for DIV/DIVU (≥1)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr  in  32  current instruction register contents (valid from DECODE)
- mem_waitrequest  in  1  bus stall; the current read/write is held while 1
- alu_cond  in  1  branch condition from ALU, valid in EXEC
- pc_zero  in  1  datapath PC equals 0
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- addr_sel  out  1  bus address: 0=PC, 1=ALU result
- ir_write  out  1  load instruction register
- target_write  out  1  latch branch/jump target in datapath
- pc_write  out  1  update PC this cycle
- pc_src  out  1  0=PC+4, 1=latched target
- reg_write  out  1  register file write enable
- hilo_write  out  1  HI/LO write enable
- state  out  3  current state encoding (debug)
- active  out  1  CPU running

## Operation
- States (encoding): FETCH=0, DECODE=1, EXEC=2, MULDIV=3, MEM=4, WB=5, HALTED=6.
- Class decode from instr: load (op 32–38), store (40,41,43), muldiv (SPECIAL funct 24–27), branch (BEQ/BNE/BLEZ/BGTZ, REGIMM rt 0/1/16/17), jump (J, JAL, SPECIAL JR/JALR), link (JAL, JALR, REGIMM rt 16/17), ALU (remaining valid SPECIAL/immediate ops), other = NOP.
- FETCH: mem_read=1, addr_sel=0 while mem_waitrequest=1; in the cycle mem_waitrequest=0, pulse ir_write and go to DECODE.
- DECODE: one cycle, then EXEC.
- EXEC, by class:
  - ALU: reg_write=1, complete.
  - load/store: go to MEM.
  - muldiv: load counter with MULT_CYCLES-1 or DIV_CYCLES-1, go to MULDIV. If the parameter is 1, hilo_write=1 and complete in EXEC.
  - branch: target_write=1 iff alu_cond. Link variants assert reg_write=1 unconditionally. Complete.
  - jump: target_write=1; JAL/JALR assert reg_write=1. Complete.
  - NOP: complete.
- MULDIV: decrement the counter each cycle. At counter==1, hilo_write=1 and complete.
- MEM: addr_sel=1. mem_read=1 (load) or mem_write=1 (store), held while mem_waitrequest=1. On acceptance, a store completes and a load goes to WB.
- WB: reg_write=1, complete.
- Complete = pc_write=1 and next state FETCH.
  - pc_src=1 if delay_pending was set before this instruction, else 0.
  - delay_pending is then set iff target_write was asserted for this instruction.
- Branch/jump in the delay slot: its target_write is suppressed. The earlier target is taken, and delay_pending clears.
- Halt: on entering FETCH with pc_zero=1 and delay_pending=0, go to HALTED and set active=0. HALTED is terminal until reset. In HALTED, all strobes are 0.

## Timing
- Reset (async assert): state=FETCH, delay_pending=0, counter=0, active=1. All strobes are 0 except mem_read=1 (FETCH).
- Reset deassertion mid-bus-transaction is legal. The transaction is abandoned and fetch restarts.
- All outputs are decoded from the registered state plus inputs (Moore, except bus-accept gating on mem_waitrequest). No output is registered.
- Latency with mem_waitrequest=0 throughout:
  - ALU, branch, jump: 3 cycles.
  - store: 4 cycles.
  - load: 5 cycles.
  - MULT: 2+MULT_CYCLES cycles.
  - DIV: 2+DIV_CYCLES cycles.
- Each wait-request cycle adds exactly one cycle.
- pc_write, ir_write, reg_write, hilo_write and target_write each pulse for exactly one cycle per instruction.

## Test plan
- Reset with reset_n=0 mid-MEM: state=0, active=1, mem_read=1 immediately (asynchronous). After release, ADDU completes with pc_write at cycle 3 and pc_src=0.
- LW with mem_waitrequest high for 2 cycles in FETCH and 3 in MEM: total 10 cycles. mem_read is held stable with addr_sel=1 in MEM. reg_write pulses once, in WB.
- BEQ with alu_cond=1 followed by ADDU: BEQ completes with pc_src=0 and target_write=1. ADDU completes with pc_src=1. The next instruction completes with pc_src=0.
- DIV with DIV_CYCLES=32: hilo_write asserted exactly at cycle 34 after FETCH entry, reg_write never asserted. Repeat with MULT_CYCLES=1: hilo_write in EXEC, 3 cycles total.
- JR followed by J in the delay slot: the J's target_write=0, the J completes with pc_src=1, and the following instruction completes with pc_src=0.
- pc_zero=1 on FETCH entry with delay_pending=0: state=6, active=0, no strobes for 20 cycles. pc_zero=1 with delay_pending=1: fetch proceeds normally.
